fetch_unit: RTL

//  Front end of the pipeline: consumer of the write-back stage's next_pc_o/brtaken_i result.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam int          INSN_BYTES       = 4;
    localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

endpackage

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the architectural PC, fetches one instruction at a time
// over a req/gnt/rvalid memory port and buffers it for decode behind valid/ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] next_pc_i,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              misalign_o
);

    localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(INSN_BYTES);

    fetch_state_e      r_state, w_state_next;
    logic [AWIDTH-1:0] r_pc, w_pc_next;
    logic [AWIDTH-1:0] r_req_pc, w_req_pc_next;
    logic              r_kill, w_kill_next;
    logic [DWIDTH-1:0] r_insn, w_insn_next;
    logic [AWIDTH-1:0] r_pc_out, w_pc_out_next;
    logic              r_insn_valid, w_insn_valid_next;
    logic              r_misalign, w_misalign_next;
    logic [AWIDTH-1:0] w_target;

    assign w_target = {next_pc_i[AWIDTH-1:2], 2'b00};

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_req_pc_next     = r_req_pc;
        w_kill_next       = r_kill;
        w_insn_next       = r_insn;
        w_pc_out_next     = r_pc_out;
        w_insn_valid_next = r_insn_valid;
        w_misalign_next   = redirect_i && (next_pc_i[1:0] != 2'b00);

        if (redirect_i) begin
            w_pc_next = w_target;
        end

        case (r_state)
            BOOT: begin
                w_state_next = REQ;
            end
            REQ: begin
                if (imem_gnt_i) begin
                    w_req_pc_next = r_pc;
                    w_state_next  = WAIT;
                    // The granted fetch is already stale if a redirect lands with it.
                    if (redirect_i) begin
                        w_kill_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    w_kill_next = 1'b0;
                    if (r_kill || redirect_i) begin
                        w_state_next = REQ;
                    end else begin
                        w_insn_next       = imem_rdata_i;
                        w_pc_out_next     = r_req_pc;
                        w_insn_valid_next = 1'b1;
                        w_pc_next         = r_req_pc + PC_STEP;
                        w_state_next      = HOLD;
                    end
                end else if (redirect_i) begin
                    w_kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i || insn_ready_i) begin
                    w_insn_valid_next = 1'b0;
                    w_state_next      = REQ;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pc         <= BASEADDR;
            r_req_pc     <= BASEADDR;
            r_kill       <= 1'b0;
            r_insn       <= '0;
            r_pc_out     <= BASEADDR;
            r_insn_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_pc     <= w_req_pc_next;
            r_kill       <= w_kill_next;
            r_insn       <= w_insn_next;
            r_pc_out     <= w_pc_out_next;
            r_insn_valid <= w_insn_valid_next;
            r_misalign   <= w_misalign_next;
        end
    end

    assign imem_req_o   = (r_state == REQ);
    assign imem_addr_o  = r_pc;
    assign insn_valid_o = r_insn_valid;
    assign insn_o       = r_insn;
    assign pc_o         = r_pc_out;
    assign misalign_o   = r_misalign;

endmodule
